// File: rtl/bsg_comm_link_client_arbiter.sv
// Round-robin, packet-locked arbiter feeding the link's single core-side input.
// Zero-latency combinational datapath; stalls pass straight through to the granted client.
module bsg_comm_link_client_arbiter #(
   parameter int width_p       = 8,
   parameter int num_clients_p = 4,
   parameter int len_width_p   = 4
) (
   input  logic                               clk_i,
   input  logic                               async_reset_i,
   input  logic                               calib_done_i,
   input  logic [num_clients_p-1:0]           client_en_i,
   input  logic [num_clients_p-1:0]           client_v_i,
   input  logic [width_p*num_clients_p-1:0]   client_data_i,
   output logic [num_clients_p-1:0]           client_ready_o,
   output logic                               link_v_o,
   output logic [width_p-1:0]                 link_data_o,
   input  logic                               link_ready_i,
   output logic [$clog2(num_clients_p)-1:0]   grant_id_o,
   output logic                               abort_o
);

   localparam int id_w = $clog2(num_clients_p);
   localparam logic [id_w-1:0] last_id = id_w'(num_clients_p - 1);

   typedef enum logic {idle_s, lock_s} state_e;

   state_e                 state_r;
   logic [id_w-1:0]        rr_ptr_r, lock_id_r, winner, sel, cand;
   logic [len_width_p-1:0] remaining_r, hdr_len;
   logic [num_clients_p-1:0] elig;
   logic                   found, xfer;
   int                     j;

   function automatic logic [id_w-1:0] wrap_inc(input logic [id_w-1:0] id);
      return (id == last_id) ? '0 : id + 1'b1;
   endfunction

   // First eligible client scanning upward from rr_ptr, wrapping at num_clients_p.
   always_comb begin
      elig   = client_v_i & client_en_i & {num_clients_p{calib_done_i}};
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      j      = 0;
      for (int i = 0; i < num_clients_p; i++) begin
         j = int'(rr_ptr_r) + i;
         if (j >= num_clients_p) j = j - num_clients_p;
         cand = id_w'(j);
         if (!found && elig[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      sel            = (state_r == lock_s) ? lock_id_r : winner;
      link_v_o       = calib_done_i & ((state_r == lock_s) ? client_v_i[lock_id_r] : found);
      grant_id_o     = link_v_o ? sel : '0;
      link_data_o    = '0;
      client_ready_o = '0;
      for (int i = 0; i < num_clients_p; i++) begin
         if (link_v_o && sel == id_w'(i)) begin
            link_data_o       = client_data_i[i*width_p +: width_p];
            client_ready_o[i] = link_ready_i;
         end
      end
      xfer    = link_v_o & link_ready_i;
      hdr_len = link_data_o[len_width_p-1:0];
      abort_o = (state_r == lock_s) & ~calib_done_i;
   end

   always_ff @(posedge clk_i or posedge async_reset_i) begin
      if (async_reset_i) begin
         state_r     <= idle_s;
         rr_ptr_r    <= '0;
         lock_id_r   <= '0;
         remaining_r <= '0;
      end else if (!calib_done_i) begin
         // Calibration loss cuts any open packet; rr_ptr deliberately untouched.
         if (state_r == lock_s) begin
            state_r     <= idle_s;
            remaining_r <= '0;
         end
      end else begin
         case (state_r)
            idle_s: if (xfer) begin
               if (hdr_len == '0) begin
                  rr_ptr_r <= wrap_inc(winner);
               end else begin
                  state_r     <= lock_s;
                  remaining_r <= hdr_len;
                  lock_id_r   <= winner;
               end
            end
            lock_s: if (xfer) begin
               remaining_r <= remaining_r - 1'b1;
               if (remaining_r == len_width_p'(1)) begin
                  state_r  <= idle_s;
                  rr_ptr_r <= wrap_inc(lock_id_r);
               end
            end
            default: state_r <= idle_s;
         endcase
      end
   end

endmodule
